// File: rtl/serial_deframer.sv
`default_nettype none
// ============================================================================
//  Module      : serial_deframer
//  Description : Serial-to-parallel frame receiver. Consumes one bit per
//                qualified clock (start 0, DATA_WIDTH data bits LSB first,
//                optional parity bit, stop 1) and presents each word with
//                one-cycle data_valid / parity_err / frame_err pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_deframer #(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bit_valid,
    input  logic                  serial_in,
    output logic [DATA_WIDTH-1:0] pdata_out,
    output logic                  data_valid,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    localparam logic [CW-1:0] c_LAST_BIT = CW'(DATA_WIDTH - 1);
    localparam logic          c_PAR_EN   = (PARITY_EN != 0);
    localparam logic          c_PAR_ODD  = (PARITY_ODD != 0);

    logic [1:0]            state_q,   state_d;
    logic [DATA_WIDTH-1:0] shreg_q,   shreg_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  par_bit_q, par_bit_d;
    logic [DATA_WIDTH-1:0] pdata_q,   pdata_d;
    logic                  dv_q,      dv_d;
    logic                  perr_q,    perr_d;
    logic                  ferr_q,    ferr_d;
    logic                  busy_q,    busy_d;

    // Next-state logic: only a qualified bit advances the frame; pulses default low
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        par_bit_d = par_bit_q;
        pdata_d   = pdata_q;
        dv_d      = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;

        if (bit_valid) begin
            case (state_q)
                S_IDLE: begin
                    // A 1 is line idle; a 0 is a start bit
                    if (!serial_in) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end
                end
                S_DATA: begin
                    // Right shift so the first data bit ends up in the LSB
                    shreg_d   = {serial_in, shreg_q[DATA_WIDTH-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == c_LAST_BIT) begin
                        state_d = c_PAR_EN ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    par_bit_d = serial_in;
                    state_d   = S_STOP;
                end
                S_STOP: begin
                    // A bad stop bit is never taken as the next start bit
                    state_d = S_IDLE;
                    if (serial_in) begin
                        pdata_d = shreg_q;
                        dv_d    = 1'b1;
                        perr_d  = c_PAR_EN & (^shreg_q ^ par_bit_q ^ c_PAR_ODD);
                    end else begin
                        ferr_d  = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            par_bit_q <= 1'b0;
            pdata_q   <= '0;
            dv_q      <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            par_bit_q <= par_bit_d;
            pdata_q   <= pdata_d;
            dv_q      <= dv_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
        end
    end

    assign pdata_out  = pdata_q;
    assign data_valid = dv_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_deframer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_deframer
//  Description : Self-checking bench for serial_deframer: table-driven frames,
//                directed multi-cycle sequences and randomized frames checked
//                against a frame-level expectation queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_deframer;

    localparam int   DW = 8;
    localparam logic PE = 1'b1;
    localparam logic PO = 1'b0;

    logic          clk;
    logic          reset;
    logic          bit_valid;
    logic          serial_in;
    logic [DW-1:0] pdata_out;
    logic          data_valid;
    logic          parity_err;
    logic          frame_err;
    logic          busy;

    serial_deframer #(
        .DATA_WIDTH (DW),
        .PARITY_EN  (1),
        .PARITY_ODD (0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bit_valid  (bit_valid),
        .serial_in  (serial_in),
        .pdata_out  (pdata_out),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic          dv;
        logic          perr;
        logic          ferr;
        logic [DW-1:0] pdata;
        int            cyc;
    } obs_t;

    obs_t obs_q[$];
    obs_t exp_q[$];

    // Record every output pulse and check the pulse invariants
    always @(negedge clk) begin
        if (reset && (data_valid || frame_err || parity_err)) begin
            obs_t o;
            o.dv = data_valid; o.perr = parity_err; o.ferr = frame_err;
            o.pdata = pdata_out; o.cyc = cyc;
            obs_q.push_back(o);
            check("dv_ferr_exclusive", 32'(data_valid & frame_err), 32'd0);
            check("perr_without_dv", 32'(parity_err & ~data_valid), 32'd0);
        end
    end

    // One consumed bit, preceded by gap cycles of bit_valid=0 with noise on serial_in
    task automatic send_bit(input logic b, input int gap);
        int n;
        n = (gap == 0) ? 0 : (gap == 1) ? 1 : int'($urandom_range(0, 3));
        for (int i = 0; i < n; i++) begin
            bit_valid = 1'b0; serial_in = 1'($urandom);
            @(posedge clk); #1;
        end
        bit_valid = 1'b1; serial_in = b;
        @(posedge clk); #1;
        bit_valid = 1'b0; serial_in = 1'($urandom);
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic flip, input logic stop,
                              input int gap, output int start_cyc);
        send_bit(1'b0, gap);
        start_cyc = cyc;
        check("busy_after_start", 32'(busy), 32'd1);
        for (int i = 0; i < DW; i++) send_bit(d[i], gap);
        if (PE) send_bit((^d) ^ PO ^ flip, gap);
        send_bit(stop, gap);
    endtask

    task automatic wait_obs(input int n);
        int t = 0;
        while (obs_q.size() < n && t < 40) begin
            @(negedge clk); #1;
            t++;
        end
        check("obs_count", 32'(obs_q.size()), 32'(n));
    endtask

    typedef struct {
        logic [DW-1:0] data;
        logic          flip;
        logic          stop;
        int            gap;
        logic          exp_dv;
        logic          exp_perr;
        logic          exp_ferr;
        logic [DW-1:0] exp_pdata;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int   sc, sc2;
        obs_t o, e;
        logic [DW-1:0] last_word;

        vecs[0] = '{8'h17, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'h17};
        vecs[1] = '{8'h17, 1'b1, 1'b1, 0, 1'b1, 1'b1, 1'b0, 8'h17};
        vecs[2] = '{8'hA5, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 8'h17};
        vecs[3] = '{8'h3C, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0, 8'h3C};
        vecs[4] = '{8'h00, 1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[5] = '{8'hFF, 1'b1, 1'b1, 2, 1'b1, 1'b1, 1'b0, 8'hFF};
        vecs[6] = '{8'h80, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b1, 8'hFF};

        reset = 1'b0; bit_valid = 1'b0; serial_in = 1'b1;
        #1;
        check("reset_pdata", 32'(pdata_out), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_pulses", {29'd0, data_valid, parity_err, frame_err}, 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;

        // Table-driven frames
        for (int k = 0; k < 7; k++) begin
            send_frame(vecs[k].data, vecs[k].flip, vecs[k].stop, vecs[k].gap, sc);
            wait_obs(1);
            if (obs_q.size() > 0) begin
                o = obs_q.pop_front();
                check($sformatf("v%0d_dv", k),    32'(o.dv),    32'(vecs[k].exp_dv));
                check($sformatf("v%0d_perr", k),  32'(o.perr),  32'(vecs[k].exp_perr));
                check($sformatf("v%0d_ferr", k),  32'(o.ferr),  32'(vecs[k].exp_ferr));
                check($sformatf("v%0d_pdata", k), 32'(o.pdata), 32'(vecs[k].exp_pdata));
                if (vecs[k].gap == 0)
                    check($sformatf("v%0d_latency", k), 32'(o.cyc - sc), 32'(DW + 1 + PE));
            end
            check($sformatf("v%0d_busy_after", k), 32'(busy), 32'd0);
        end

        // Back-to-back frames with no idle bit
        send_frame(8'h01, 1'b0, 1'b1, 0, sc);
        send_frame(8'hFE, 1'b0, 1'b1, 0, sc2);
        wait_obs(2);
        if (obs_q.size() >= 2) begin
            o = obs_q.pop_front();
            e = obs_q.pop_front();
            check("b2b_first_word", 32'(o.pdata), 32'h01);
            check("b2b_first_dv", 32'(o.dv & ~o.perr), 32'd1);
            check("b2b_second_word", 32'(e.pdata), 32'hFE);
            check("b2b_second_dv", 32'(e.dv & ~e.perr), 32'd1);
            check("b2b_spacing", 32'(e.cyc - o.cyc), 32'd11);
        end

        // Asynchronous reset in the middle of a frame
        send_bit(1'b0, 0);
        send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b0, 0);
        #2 reset = 1'b0;
        #1;
        check("midreset_pdata", 32'(pdata_out), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        check("midreset_no_events", 32'(obs_q.size()), 32'd0);
        obs_q.delete();
        send_frame(8'h55, 1'b0, 1'b1, 0, sc);
        wait_obs(1);
        if (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            check("post_reset_word", 32'(o.pdata), 32'h55);
            check("post_reset_flags", {29'd0, o.dv, o.perr, o.ferr}, 32'b100);
        end

        // Randomized frames against a frame-level expectation queue
        last_word = 8'h55;
        obs_q.delete();
        for (int f = 0; f < 40; f++) begin
            logic [DW-1:0] d;
            logic flip, stop;
            int idles;
            d     = DW'($urandom);
            flip  = ($urandom_range(0, 3) == 0);
            stop  = ($urandom_range(0, 4) != 0);
            idles = $urandom_range(0, 2);
            for (int i = 0; i < idles; i++) send_bit(1'b1, 2);
            send_frame(d, flip, stop, 2, sc);
            e.cyc = 0;
            if (stop) begin
                e.dv = 1'b1; e.perr = flip; e.ferr = 1'b0; e.pdata = d;
                last_word = d;
            end else begin
                e.dv = 1'b0; e.perr = 1'b0; e.ferr = 1'b1; e.pdata = last_word;
            end
            exp_q.push_back(e);
        end
        wait_obs(exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check($sformatf("rnd%0d_flags", i), {29'd0, obs_q[i].dv, obs_q[i].perr, obs_q[i].ferr},
                  {29'd0, exp_q[i].dv, exp_q[i].perr, exp_q[i].ferr});
            check($sformatf("rnd%0d_pdata", i), 32'(obs_q[i].pdata), 32'(exp_q[i].pdata));
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_deframer.md
# serial_deframer

Receives the bit stream produced by the 8-bit universal shift register's `serial_out`, one bit per qualified clock, and assembles framed words. Each frame is a start bit (0), DATA_WIDTH data bits LSB first, an optional parity bit, and a stop bit (1). Each good word is presented in parallel with a one-cycle valid pulse. It sits directly downstream of the shift register and converts its serial output back into parallel words for the consumer logic.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame.
- `PARITY_EN`, default 1: 1 means a parity bit follows the data; 0 means there is no parity bit.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd parity; ignored when PARITY_EN=0.

- `clk`, in, 1: single clock; all state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset; state clears immediately when low.
- `bit_valid`, in, 1: qualifies `serial_in`; a bit is consumed only on edges where `bit_valid`=1.
- `serial_in`, in, 1: serial bit; connects to the shift register's `serial_out`.
- `pdata_out`, out, DATA_WIDTH: last delivered word, held until the next delivery.
- `data_valid`, out, 1: one-cycle pulse when `pdata_out` is updated.
- `parity_err`, out, 1: one-cycle pulse coincident with `data_valid` when the parity check fails.
- `frame_err`, out, 1: one-cycle pulse when the stop bit is sampled as 0.
- `busy`, out, 1: high whenever the state is not IDLE.

## Operation
- FSM states:
  - IDLE: consumed bit 0 moves to DATA with `bit_cnt`=0; consumed bit 1 stays in IDLE (line idle).
  - DATA: shifts the consumed bit into the MSB of `shreg` (right-shift), so the first bit lands in the LSB after DATA_WIDTH bits. `bit_cnt` increments per consumed bit. After DATA_WIDTH bits the FSM moves to PARITY if PARITY_EN, otherwise to STOP.
  - PARITY: the consumed bit is stored as `par_bit`; next state is STOP.
  - STOP: on a consumed bit, the FSM always returns to IDLE.
    - Bit = 1: load `pdata_out`<=`shreg` and pulse `data_valid`.
    - Bit = 0: pulse `frame_err`; do not update `pdata_out`; do not pulse `data_valid`.
- `bit_cnt` width is clog2(DATA_WIDTH+1). It never wraps, because it is cleared on entry to DATA.
- Parity check:
  - Even: `parity_err` = XOR(`shreg`) ^ `par_bit`.
  - Odd: `parity_err` = ~(XOR(`shreg`) ^ `par_bit`).
  - Evaluated only on a good stop bit. A word with a parity error is still delivered with `data_valid`=1 and `parity_err`=1.
- Edges with `bit_valid`=0 leave all state unchanged, whatever the value of `serial_in`.
- A stop bit of 0 is not reinterpreted as a new start bit. The next start bit must be a fresh consumed 0 in IDLE.

## Timing
- Reset values (applied asynchronously while `reset`=0):
  - state: IDLE
  - `shreg`, `bit_cnt`, `par_bit`: 0
  - `pdata_out`: 0
  - `data_valid`, `parity_err`, `frame_err`, `busy`: 0
- Reset released mid-frame: the partial frame is discarded and the block waits in IDLE for a new start bit.
- All outputs are registered. `data_valid`, `parity_err` and `frame_err` go high in the cycle after the edge that consumed the stop bit, for exactly one cycle.
- Latency: when `bit_valid` is held at 1, a frame takes DATA_WIDTH+2+PARITY_EN edges from the start-bit edge through the stop-bit edge. The output appears one cycle after the stop-bit edge.
- `busy` rises in the cycle after the start-bit edge and falls in the cycle after the stop-bit edge, coincident with the `data_valid` or `frame_err` pulse.
- Back-to-back frames: a start bit consumed on the edge immediately after the stop bit is accepted. No idle bit is required, and no bit is lost.
- `bit_valid` gaps of any length inside a frame are legal; they only stretch the frame.
- `data_valid` and `frame_err` are mutually exclusive. `parity_err` is never high without `data_valid`.

## Test plan
- Reset, then an even-parity frame with `bit_valid`=1 every cycle. Bit sequence 0, 1,1,1,0,1,0,0,0, parity 0, stop 1 → `pdata_out`=8'h17, `data_valid` pulse, `parity_err`=0, 11 edges start to stop.
- Same frame with the parity bit flipped to 1 → `pdata_out`=8'h17, `data_valid`=1 and `parity_err`=1 in the same cycle.
- Frame for 8'hA5 with the stop bit = 0 → `frame_err` pulse, no `data_valid`, `pdata_out` keeps its previous value, `busy`=0 afterwards.
- Frame for 8'h3C with `bit_valid` toggled 1/0 every cycle, and `serial_in` randomized on the invalid cycles → `pdata_out`=8'h3C, no errors.
- Two back-to-back frames, 8'h01 then 8'hFE, with no idle bit between them → two `data_valid` pulses 11 cycles apart with the correct words.
- `reset` driven low asynchronously after 4 data bits, then released, followed by a full frame for 8'h55 → outputs clear immediately on reset; the next frame delivers 8'h55 with no error pulses.
